// File: rtl/decode_stage_nw_pkg.sv
// riscv_core: shared types for the decode slice.
//   alu_ctl_t  - ALU operation selector (ALUCTL_*), ALUCTL_ADD encodes as 0
//   pred_t     - branch predictor direction
//   dec_t      - one decoded lane, carries its own valid bit
//   DEC_RESET  - reset value of dec_t (all zero, ALUCTL_ADD)
// Also provides a default for the ADDR_WIDTH macro so the PC width has a
// value when the build does not define one.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package riscv_core;

  typedef enum logic [3:0] {
    ALUCTL_ADD  = 4'd0,
    ALUCTL_SUB  = 4'd1,
    ALUCTL_SLL  = 4'd2,
    ALUCTL_SLT  = 4'd3,
    ALUCTL_SLTU = 4'd4,
    ALUCTL_XOR  = 4'd5,
    ALUCTL_SRL  = 4'd6,
    ALUCTL_SRA  = 4'd7,
    ALUCTL_OR   = 4'd8,
    ALUCTL_AND  = 4'd9,
    ALUCTL_LUI  = 4'd10
  } alu_ctl_t;

  typedef enum logic {
    PRED_NOT_TAKEN = 1'b0,
    PRED_TAKEN     = 1'b1
  } pred_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    alu_ctl_t    alu_operation;
    logic        uses_imm;
    logic        reg_write;
    logic        is_branch;
    logic        is_jump;
    logic        is_load;
    logic        is_store;
    logic        illegal;
  } dec_t;

  localparam dec_t DEC_RESET = '{
    valid: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0,
    alu_operation: ALUCTL_ADD, uses_imm: 1'b0, reg_write: 1'b0,
    is_branch: 1'b0, is_jump: 1'b0, is_load: 1'b0, is_store: 1'b0,
    illegal: 1'b0
  };

  // alt selects SUB/SRA (instr[30]); callers mask it where it has no meaning.
  function automatic alu_ctl_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_ctl_t op;
    case (f3)
      3'b000:  op = alt ? ALUCTL_SUB : ALUCTL_ADD;
      3'b001:  op = ALUCTL_SLL;
      3'b010:  op = ALUCTL_SLT;
      3'b011:  op = ALUCTL_SLTU;
      3'b100:  op = ALUCTL_XOR;
      3'b101:  op = alt ? ALUCTL_SRA : ALUCTL_SRL;
      3'b110:  op = ALUCTL_OR;
      default: op = ALUCTL_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_nw_redirect_select.sv
// redirect_select: priority encoder over per-lane inconsistency flags.
// Lane 0 is the oldest and wins.
// Ports:
//   incons - per-lane inconsistency (already masked by lane valid)
//   found  - at least one lane is inconsistent
//   k      - index of the oldest inconsistent lane (0 when none)
//   kill   - lanes younger than k (all zero when none)
module redirect_select #(
  parameter int WIDTH  = 2,
  parameter int LANE_W = 1
) (
  input  logic [WIDTH-1:0]  incons,
  output logic              found,
  output logic [LANE_W-1:0] k,
  output logic [WIDTH-1:0]  kill
);

  always_comb begin
    found = 1'b0;
    k     = '0;
    kill  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (found) begin
        kill[i] = 1'b1;
      end else if (incons[i]) begin
        found = 1'b1;
        k     = LANE_W'(i);
      end
    end
  end

endmodule

// File: rtl/decoder.sv
// decoder: combinational RV32I decode of one lane plus a front-end
// consistency check against what the predictor told fetch.
// Ports:
//   valid          - lane carries an instruction
//   instr, pc      - raw instruction and its PC
//   guesses_branch - predictor flagged this lane as a branch
//   prediction     - predicted direction
//   dec            - decoded lane (dec.valid = valid)
//   inconsistent   - fetch followed the wrong path after this lane
//   new_pc         - correct next PC when inconsistent
module decoder
  import riscv_core::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  valid,
  input  logic [31:0]           instr,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  guesses_branch,
  input  pred_t                 prediction,
  output dec_t                  dec,
  output logic                  inconsistent,
  output logic [ADDR_WIDTH-1:0] new_pc
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic        is_jal, is_control, pred_taken;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign i_imm  = {{20{instr[31]}}, instr[31:20]};
  assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm  = {instr[31:12], 12'b0};
  assign j_imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec       = DEC_RESET;
    dec.valid = valid;
    dec.rs1   = instr[19:15];
    dec.rs2   = instr[24:20];
    case (opcode)
      OPC_OP_IMM: begin
        dec.imm = i_imm; dec.uses_imm = 1'b1; dec.reg_write = 1'b1;
        dec.alu_operation = alu_from_funct3(f3, (f3 == 3'b101) & instr[30]);
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
        dec.alu_operation = alu_from_funct3(f3, instr[30]);
      end
      OPC_LUI: begin
        dec.imm = u_imm; dec.uses_imm = 1'b1; dec.reg_write = 1'b1;
        dec.alu_operation = ALUCTL_LUI;
      end
      OPC_AUIPC: begin
        dec.imm = u_imm; dec.uses_imm = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = j_imm; dec.is_jump = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        dec.imm = i_imm; dec.is_jump = 1'b1; dec.reg_write = 1'b1; dec.uses_imm = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = b_imm; dec.is_branch = 1'b1; dec.alu_operation = ALUCTL_SUB;
      end
      OPC_LOAD: begin
        dec.imm = i_imm; dec.is_load = 1'b1; dec.reg_write = 1'b1; dec.uses_imm = 1'b1;
      end
      OPC_STORE: begin
        dec.imm = s_imm; dec.is_store = 1'b1; dec.uses_imm = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.reg_write) dec.rd = instr[11:7];
  end

  // Only what decode can prove is checked: a JAL is always taken to a known
  // target, and a non-control lane must never have been followed as taken.
  // Conditional branches and JALR are resolved later in the pipeline.
  assign is_jal     = (opcode == OPC_JAL);
  assign is_control = is_jal | (opcode == OPC_JALR) | (opcode == OPC_BRANCH);
  assign pred_taken = guesses_branch & (prediction == PRED_TAKEN);

  assign inconsistent = valid & ((is_jal & ~pred_taken) | (~is_control & pred_taken));
  assign new_pc       = is_jal ? (pc + ADDR_WIDTH'($signed(j_imm))) : (pc + ADDR_WIDTH'(4));

endmodule

// File: rtl/decode_stage_nw.sv
// decode_stage_nw: N-lane decode stage between fetch and rename/dispatch.
// Decodes a WIDTH-lane fetch bundle, kills lanes younger than the oldest
// front-end mispredict, raises one redirect to fetch, and holds decoded
// bundles in an output register backed by a one-entry skid register.
//
// Handshake: a transfer happens on a clock edge where valid & ready are both
// high. in_ready depends only on the skid register, never on out_ready, so
// the upstream ready path is registered. out_valid never drops without a
// transfer except on reset/flush.
//
// Ports:
//   clk, reset (sync, active-high), flush (sync)
//   in_valid/in_ready, in_lane_valid, in_instr, in_pc, in_guesses_branch,
//   in_prediction                     - fetch bundle
//   out_valid/out_ready, out_dec      - decoded bundle
//   fb_valid, fb_pc, fb_lane          - redirect to fetch (combinational)
//   perf_instr, perf_redirect         - only with DECODE_PERF_CNT_EN
// Build option: DECODE_PERF_CNT_EN adds saturating 32-bit counters of lanes
// stored and of redirects issued.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module decode_stage_nw
  import riscv_core::*;
#(
  parameter int WIDTH      = 2,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  localparam int LANE_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [WIDTH-1:0]                 in_lane_valid,
  input  logic [WIDTH-1:0][31:0]           in_instr,
  input  logic [WIDTH-1:0][ADDR_WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0]                 in_guesses_branch,
  input  pred_t [WIDTH-1:0]                in_prediction,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output dec_t [WIDTH-1:0]                 out_dec,
  output logic                             fb_valid,
  output logic [ADDR_WIDTH-1:0]            fb_pc,
  output logic [LANE_W-1:0]                fb_lane
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_instr,
  output logic [31:0]                      perf_redirect
`endif
);

  dec_t [WIDTH-1:0]                 lane_dec;
  dec_t [WIDTH-1:0]                 dec_in;
  dec_t [WIDTH-1:0]                 sk_dec;
  logic [WIDTH-1:0]                 lane_incons;
  logic [WIDTH-1:0][ADDR_WIDTH-1:0] lane_new_pc;
  logic [WIDTH-1:0]                 kill;
  logic [LANE_W-1:0]                k;
  logic                             found;
  logic                             sk_full;
  logic                             accept, clear, store, any_valid;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    decoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_decoder (
      .valid          (in_lane_valid[i]),
      .instr          (in_instr[i]),
      .pc             (in_pc[i]),
      .guesses_branch (in_guesses_branch[i]),
      .prediction     (in_prediction[i]),
      .dec            (lane_dec[i]),
      .inconsistent   (lane_incons[i]),
      .new_pc         (lane_new_pc[i])
    );
  end

  redirect_select #(.WIDTH(WIDTH), .LANE_W(LANE_W)) u_redirect_select (
    .incons (lane_incons),
    .found  (found),
    .k      (k),
    .kill   (kill)
  );

  assign in_ready = ~sk_full;
  assign accept   = in_valid & in_ready;
  assign clear    = reset | flush;

  always_comb begin
    dec_in    = lane_dec;
    any_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      dec_in[i].valid = lane_dec[i].valid & ~kill[i];
      any_valid       = any_valid | dec_in[i].valid;
    end
  end

  // A bundle with no surviving lane is consumed but never stored.
  assign store = accept & any_valid & ~clear;

  // Redirect fields are held at zero whenever no redirect is issued, so
  // fetch never sees a stale target.
  assign fb_valid = accept & found & ~clear;
  assign fb_pc    = fb_valid ? lane_new_pc[k] : '0;
  assign fb_lane  = fb_valid ? k : '0;

  always_ff @(posedge clk) begin
    if (clear) begin
      out_valid <= 1'b0;
      sk_full   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        out_dec[i] <= DEC_RESET;
        sk_dec[i]  <= DEC_RESET;
      end
    end else if (~out_valid | out_ready) begin
      // Output register is free this cycle; the skid entry is older than
      // anything on the input, and in_ready is low while it is full.
      if (sk_full) begin
        out_valid <= 1'b1;
        out_dec   <= sk_dec;
        sk_full   <= 1'b0;
      end else begin
        out_valid <= store;
        if (store) out_dec <= dec_in;
      end
    end else if (store) begin
      sk_dec  <= dec_in;
      sk_full <= 1'b1;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic [3:0]  store_cnt;
  logic [32:0] instr_sum;

  always_comb begin
    store_cnt = '0;
    for (int i = 0; i < WIDTH; i++) store_cnt = store_cnt + 4'(dec_in[i].valid);
  end

  assign instr_sum = {1'b0, perf_instr} + 33'(store_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_instr    <= '0;
      perf_redirect <= '0;
    end else begin
      if (store) perf_instr <= instr_sum[32] ? 32'hFFFF_FFFF : instr_sum[31:0];
      if (fb_valid && (perf_redirect != 32'hFFFF_FFFF)) perf_redirect <= perf_redirect + 32'd1;
    end
  end
`endif

endmodule

// File: doc/decode_stage_nw.md
# decode_stage_nw

Parametrised N-lane decode stage with a ready/valid handshake on both sides and a one-entry skid buffer, so upstream ready is registered. Sits between fetch and rename/dispatch. Each cycle it accepts one fetch bundle of `WIDTH` lanes and decodes every lane. It kills the lanes younger than the oldest branch mispredict and sends one redirect to fetch. Decoded bundles are held under downstream back-pressure without loss.

## Interface
Parameters:
- `WIDTH`, default 2: number of lanes (1–8). Lane 0 is the oldest.
- `ADDR_WIDTH`, default `` `ADDR_WIDTH ``: PC width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous pipeline flush.
- `in_valid` in 1: fetch bundle present.
- `in_lane_valid` in `WIDTH`: per-lane instruction valid.
- `in_instr` in `WIDTH`×32: raw instructions.
- `in_pc` in `WIDTH`×`ADDR_WIDTH`: lane PCs.
- `in_guesses_branch` in `WIDTH`: predictor flagged this lane as a branch.
- `in_prediction` in `WIDTH`×`pred_t`: predicted direction.
- `in_ready` out 1: bundle accepted when `in_valid & in_ready`.
- `out_valid` out 1: decoded bundle present.
- `out_ready` in 1: downstream takes the bundle.
- `out_dec` out `WIDTH`×`dec_t`: decoded lanes, each with its own `.valid`.
- `fb_valid` out 1: redirect request.
- `fb_pc` out `ADDR_WIDTH`: redirect target.
- `fb_lane` out `$clog2(WIDTH)` (minimum 1 bit): lane that caused the redirect.

## Operation
- `accept = in_valid & in_ready`.
- `in_ready = ~sk_full`, where `sk_full` is a register.
- Each lane is decoded combinationally from the inputs. A lane is effective when `in_lane_valid[i]` is set.
- Redirect selection:
  - `k` is the lowest effective lane with a branch inconsistency.
  - `fb_valid = accept & found`; `fb_pc` is the new PC from lane `k`; `fb_lane = k`.
  - Lanes with index greater than `k` get `.valid = 0` before storage. Lane `k` itself stays valid.
  - Only one redirect is issued per bundle.
- Storage uses an output register `OR` (`out_valid`, `out_dec`) and a skid register `SK`. Each cycle, in priority order:
  1. `reset | flush`: `out_valid = 0`, `sk_full = 0`, input dropped. `fb_valid` is forced to 0 in that cycle.
  2. If `~out_valid | out_ready` (OR free): OR loads `SK` when `sk_full`, and `sk_full` clears. Otherwise OR loads the accepted bundle, or `out_valid = 0` if nothing was accepted.
  3. If OR is stalled and `accept`: the bundle goes to `SK` and `sk_full = 1`.
- A bundle in which no lane is effective after the kill is accepted and discarded. It raises no `out_valid` and uses no storage.
- Bundles are delivered in order. None is duplicated or lost.
- Fetch must redirect in the same cycle that `fb_valid` is high. The bundle that follows is on the correct path.

## Timing
- Latency: 1 cycle from `accept` to `out_valid` when OR is free; 2 cycles when routed through `SK`.
- `fb_*` is combinational from the inputs in the accept cycle. It is not registered.
- Reset values:
  - `out_valid = 0`; `out_dec` = all zero with `alu_operation = ALUCTL_ADD`.
  - `in_ready = 1`.
  - `fb_valid = 0`, `fb_pc = 0`, `fb_lane = 0`.
- Full case: with `sk_full = 1`, `in_ready = 0` in the next cycle. One accept can occur while OR is stalled; none after that.
- Simultaneous `out_ready` and `accept` with `sk_full = 0`: OR is replaced by the new bundle, and throughput is 1 bundle per cycle.
- Simultaneous `flush` and `accept`: flush wins and the bundle is lost. Fetch is responsible for re-fetching it.
- Reset or flush while in the middle of a stall clears both registers in one cycle.

## Configuration
- `DECODE_PERF_CNT_EN` defined:
  - Adds output `perf_instr` (32 bits): count of lanes stored valid into OR/`SK`.
  - Adds output `perf_redirect` (32 bits): count of `fb_valid` cycles.
  - Both counters clear on `reset` only (not `flush`), saturate at `32'hFFFF_FFFF`, and add up to `WIDTH` per cycle.
- Undefined: the ports are absent and no counter logic is built.

## Structure
- Package `riscv_core` holds `dec_t` (decoded lane struct), `pred_t`, `ALUCTL_*`, and `DEC_RESET` (the reset value of `dec_t`).
- The existing `decoder` is instantiated `WIDTH` times.
- New sub-module `redirect_select`: a parametrised priority encoder over the inconsistency vector. It outputs `found`, `k`, and the kill mask.

## Test plan
- `WIDTH=2`, two plain ADDI lanes at PCs `0x100`/`0x104`, `out_ready = 1` → next cycle `out_valid = 1`, both lanes valid, `fb_valid` stays 0.
- Lane 0 is a JAL `+0x40` at PC `0x200` with `guesses_branch = 0` → `fb_valid = 1`, `fb_pc = 0x240`, `fb_lane = 0`; stored lane 1 is invalid.
- Both lanes inconsistent → redirect from lane 0 only; exactly one `fb_valid` pulse.
- `out_ready = 0` for 3 cycles with bundles A and B offered → A in OR, B in `SK`, `in_ready = 0`. Releasing `out_ready` delivers A, then B, in consecutive cycles.
- `flush` asserted with `SK` full → next cycle `out_valid = 0`, `in_ready = 1`.
- With `DECODE_PERF_CNT_EN`: 5 full bundles and 1 redirect on lane 0 → `perf_instr = 9`, `perf_redirect = 1`.
